// File: rtl/dram_bridge_pkg.sv
// Shared types and line geometry for the 32-bit word to 128-bit line bridge.
package dram_bridge_pkg;

  localparam int LINE_W       = 128;
  localparam int OFFSET_W     = 4;
  localparam int WORD_SEL_LSB = 2;
  localparam int WORD_W       = 32;
  localparam int WORDS        = LINE_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    EVICT,
    FILL
  } state_e;

endpackage

// File: rtl/dram_line_merge.sv
// Byte-strobe merge of one 32-bit word into a 128-bit line, plus read-back
// of the selected word after the merge.
module dram_line_merge
  import dram_bridge_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [1:0]        word_sel_i,
  input  logic [3:0]        wstrb_i,
  input  logic [31:0]       wdata_i,
  output logic [LINE_W-1:0] line_o,
  output logic [31:0]       word_o
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      for (gj = 0; gj < 4; gj++) begin : g_byte
        assign line_o[32*gi + 8*gj +: 8] =
          (word_sel_i == 2'(gi) && wstrb_i[gj]) ? wdata_i[8*gj +: 8]
                                                : line_i[32*gi + 8*gj +: 8];
      end
    end
  endgenerate

  assign word_o = line_o[{word_sel_i, 5'b0} +: 32];

endmodule

// File: rtl/dram_line_bridge.sv
// Word-to-line bridge in front of dram_control with a single write-back line
// buffer. Optional flush port pair is enabled by DRAM_BRIDGE_FLUSH_EN.
module dram_line_bridge
  import dram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
`ifdef DRAM_BRIDGE_FLUSH_EN
  input  logic              flush_req,
  output logic              flush_done,
`endif
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_wstrb,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wmask,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam int TAG_W = ADDR_W - OFFSET_W;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                line_valid_q, line_valid_d;
  logic                line_dirty_q, line_dirty_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_wmask_q, mem_wmask_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
`ifdef DRAM_BRIDGE_FLUSH_EN
  logic                flush_done_q, flush_done_d;
  logic                flush_op_q, flush_op_d;
`endif

  logic [TAG_W-1:0]    cpu_tag;
  logic [1:0]          word_sel;
  logic                hit;
  logic [LINE_W-1:0]   merged_line;
  logic [31:0]         merged_word;
  logic                unused_addr_bits;

  assign cpu_tag          = cpu_addr[ADDR_W-1:OFFSET_W];
  assign word_sel         = cpu_addr[WORD_SEL_LSB +: 2];
  assign hit              = line_valid_q && (tag_q == cpu_tag);
  assign unused_addr_bits = ^cpu_addr[WORD_SEL_LSB-1:0];

  dram_line_merge u_merge (
    .line_i     (line_q),
    .word_sel_i (word_sel),
    .wstrb_i    (cpu_wstrb),
    .wdata_i    (cpu_wdata),
    .line_o     (merged_line),
    .word_o     (merged_word)
  );

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    tag_d        = tag_q;
    line_valid_d = line_valid_q;
    line_dirty_d = line_dirty_q;
    cpu_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    mem_valid_d  = mem_valid_q;
    mem_wmask_d  = mem_wmask_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef DRAM_BRIDGE_FLUSH_EN
    flush_done_d = 1'b0;
    flush_op_d   = flush_op_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef DRAM_BRIDGE_FLUSH_EN
        if (flush_req) begin
          if (line_valid_q && line_dirty_q) begin
            flush_op_d = 1'b1;
            state_d    = EVICT;
          end else begin
            line_valid_d = 1'b0;
            flush_done_d = 1'b1;
          end
        end else
`endif
        if (cpu_valid) begin
          if (hit) begin
            line_d      = merged_line;
            cpu_rdata_d = merged_word;
            cpu_ready_d = 1'b1;
            state_d     = RESP;
            if (|cpu_wstrb) line_dirty_d = 1'b1;
          end else if (line_dirty_q) begin
            state_d = EVICT;
          end else begin
            state_d = FILL;
          end
        end
      end

      RESP: state_d = IDLE;

      // The first cycle in EVICT/FILL loads the request; mem_valid_q being
      // low marks that entry cycle since it stays high until the handshake.
      EVICT: begin
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          mem_wmask_d = 1'b1;
          mem_addr_d  = {tag_q, {OFFSET_W{1'b0}}};
          mem_wdata_d = line_q;
        end else if (mem_ready) begin
          mem_valid_d  = 1'b0;
          line_dirty_d = 1'b0;
          state_d      = FILL;
`ifdef DRAM_BRIDGE_FLUSH_EN
          if (flush_op_q) begin
            flush_op_d   = 1'b0;
            line_valid_d = 1'b0;
            flush_done_d = 1'b1;
            state_d      = IDLE;
          end
`endif
        end
      end

      FILL: begin
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          mem_wmask_d = 1'b0;
          mem_addr_d  = {cpu_tag, {OFFSET_W{1'b0}}};
        end else if (mem_ready) begin
          mem_valid_d  = 1'b0;
          line_d       = mem_rdata;
          tag_d        = cpu_tag;
          line_valid_d = 1'b1;
          line_dirty_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      line_q       <= '0;
      tag_q        <= '0;
      line_valid_q <= 1'b0;
      line_dirty_q <= 1'b0;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_valid_q  <= 1'b0;
      mem_wmask_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
`ifdef DRAM_BRIDGE_FLUSH_EN
      flush_done_q <= 1'b0;
      flush_op_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      tag_q        <= tag_d;
      line_valid_q <= line_valid_d;
      line_dirty_q <= line_dirty_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mem_valid_q  <= mem_valid_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef DRAM_BRIDGE_FLUSH_EN
      flush_done_q <= flush_done_d;
      flush_op_q   <= flush_op_d;
`endif
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef DRAM_BRIDGE_FLUSH_EN
  assign flush_done = flush_done_q;
`endif

endmodule
